// File: rtl/rvfi_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_trace_monitor
// Brief    : On-the-fly RVFI retirement checker with sticky error flags and
//            a trace-record FIFO drained over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_trace_monitor #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 16,
  parameter int DROPW = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rvfi_valid,
  input  logic [63:0]       rvfi_order,
  input  logic [ILEN-1:0]   rvfi_insn,
  input  logic              rvfi_trap,
  input  logic              rvfi_halt,
  input  logic [XLEN-1:0]   rvfi_pc_rdata,
  input  logic [XLEN-1:0]   rvfi_pc_wdata,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [XLEN-1:0]   rvfi_rd_wdata,
  input  logic              clear_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_order,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_insn,
  output logic [4:0]        out_rd_addr,
  output logic [XLEN-1:0]   out_rd_wdata,
  output logic              out_trap,
  output logic              err_order,
  output logic              err_pc,
  output logic              err_x0,
  output logic              err_align,
  output logic              err_halt,
  output logic              overflow,
  output logic [DROPW-1:0]  dropped,
  output logic              halted
);

  localparam int AW   = $clog2(DEPTH);
  localparam int RECW = 64 + XLEN + ILEN + 5 + XLEN + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_next;

  logic [63:0]     last_order;
  logic [XLEN-1:0] last_pc_wdata;
  logic            last_trap;

  logic [RECW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic            accept, full, push, pop, drop;
  logic            order_bad, pc_bad, x0_bad, align_bad, halt_bad;
  logic [RECW-1:0] record, head;

  // A retirement is only processed (checked, recorded) before halt.
  assign accept    = rvfi_valid && (state != HALTED);
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;
  assign halted    = (state == HALTED);

  assign order_bad = accept && (state == TRACK) && (rvfi_order != last_order + 64'd1);
  assign pc_bad    = accept && (state == TRACK) && !last_trap && (rvfi_pc_rdata != last_pc_wdata);
  assign x0_bad    = accept && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
  assign align_bad = accept && !rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00);
  assign halt_bad  = rvfi_valid && (state == HALTED);

  assign record = {rvfi_order, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata, rvfi_trap};
  // Head is masked when empty so stale storage never leaks onto the outputs.
  assign head   = out_valid ? mem[rd_ptr] : '0;
  assign {out_order, out_pc, out_insn, out_rd_addr, out_rd_wdata, out_trap} = head;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: first retirement starts tracking, halt retirement is terminal.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rvfi_valid) state_next = rvfi_halt ? HALTED : TRACK;
      TRACK:   if (rvfi_valid && rvfi_halt) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // Remember the previous retirement for the sequence and continuity checks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_order    <= '0;
      last_pc_wdata <= '0;
      last_trap     <= 1'b0;
    end else if (accept) begin
      last_order    <= rvfi_order;
      last_pc_wdata <= rvfi_pc_wdata;
      last_trap     <= rvfi_trap;
    end
  end

  // Sticky flags: clear_err drops old errors but a same-cycle new error wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_order <= 1'b0;
      err_pc    <= 1'b0;
      err_x0    <= 1'b0;
      err_align <= 1'b0;
      err_halt  <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= '0;
    end else begin
      err_order <= (err_order & ~clear_err) | order_bad;
      err_pc    <= (err_pc    & ~clear_err) | pc_bad;
      err_x0    <= (err_x0    & ~clear_err) | x0_bad;
      err_align <= (err_align & ~clear_err) | align_bad;
      err_halt  <= (err_halt  & ~clear_err) | halt_bad;
      overflow  <= (overflow  & ~clear_err) | drop;
      if (clear_err)
        dropped <= DROPW'(drop);
      else if (drop && (dropped != '1))
        dropped <= dropped + 1'b1;
    end
  end

  // FIFO pointers and occupancy; push+pop on a full FIFO keeps the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= record;
  end

endmodule
`default_nettype wire
